dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single data-memory port between the pipeline MEM stage (CPU) and an
// external debug/loader master (DBG). Sits between the EX/MEM register outputs and
// datamemory; grants one access per cycle, stalls the pipeline when the CPU loses
// arbitration, and supports a DBG lock for multi-beat program/data loading.
// PARAMETERS
// DATA_W      32  data width
// DM_ADDRESS  9   data-memory byte address width
// STARVE_MAX  4   contended cycles DBG may wait before it wins (>=1)
// PORTS
// clk         in   1           clock, all state updates on posedge
// reset       in   1           synchronous reset, active-low (0 = reset)
// cpu_rd      in   1           CPU load request (MEM stage MemRead)
// cpu_wr      in   1           CPU store request (MEM stage MemWrite)
// cpu_addr    in   DM_ADDRESS  CPU address
// cpu_wdata   in   DATA_W      CPU store data
// cpu_funct3  in   3           CPU access size/sign
// cpu_rdata   out  DATA_W      load data to MEM/WB (valid when cpu_rd & !cpu_stall)
// cpu_stall   out  1           freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
// dbg_req     in   1           DBG access request, held until dbg_gnt
// dbg_we      in   1           1 = write, 0 = read (word access, funct3=3'b010)
// dbg_lock    in   1           DBG requests exclusive ownership after its grant
// dbg_addr    in   DM_ADDRESS  DBG address
// dbg_wdata   in   DATA_W      DBG write data
// dbg_gnt     out  1           DBG access performed this cycle
// dbg_rvalid  out  1           registered: dbg_rdata valid (cycle after granted read)
// dbg_rdata   out  DATA_W      registered DBG read data
// mem_rd/mem_wr out 1          to datamemory MemRead/MemWrite
// mem_addr    out  DM_ADDRESS  to datamemory address
// mem_wdata   out  DATA_W      to datamemory write data
// mem_funct3  out  3           to datamemory funct3
// mem_rdata   in   DATA_W      datamemory read data (combinational, same cycle)
// BEHAVIOUR
// - cpu_act = cpu_rd|cpu_wr. Memory: write at posedge, read combinational.
// - FSM states: ARB, LOCK. Reset (reset==0) -> ARB, dbg_wait=0, dbg_rvalid=0,
//   dbg_rdata=0. While reset==0: mem_rd=mem_wr=0, dbg_gnt=0, cpu_stall=0.
// - ARB grant: only one requester -> it wins. Both: CPU wins unless
//   dbg_wait==STARVE_MAX, then DBG wins. Neither: mem_rd=mem_wr=0, mux selects CPU.
// - dbg_wait (width $clog2(STARVE_MAX+1)): +1 each cycle dbg_req & !dbg_gnt,
//   saturates at STARVE_MAX; cleared on dbg_gnt or dbg_req==0.
// - ARB -> LOCK when dbg_gnt & dbg_lock. In LOCK DBG always wins; cpu_stall=cpu_act
//   every LOCK cycle even if dbg_req==0. LOCK -> ARB at clock edge after a cycle with
//   dbg_lock==0; that cycle is still LOCK (DBG-owned).
// - cpu_stall = cpu_act & !cpu_granted (combinational, same cycle). Stalled CPU
//   request is held by the pipeline and retried; no CPU store may be issued twice.
// - Granted master drives mem_* fully; non-granted master has zero effect on memory.
// - cpu_rdata = mem_rdata unconditionally (consumer qualifies with cpu_stall).
// - dbg_rvalid <= dbg_gnt & !dbg_we; dbg_rdata <= mem_rdata when so, else holds.
// - Same-address DBG write then CPU read in consecutive cycles: CPU sees new data.
// - Reset mid-LOCK: return to ARB, pending grants dropped, no memory write in reset.
// TESTING
// - CPU-only: cpu_wr addr 0x10 data 0xDEADBEEF, then cpu_rd 0x10 -> cpu_stall=0,
//   cpu_rdata=0xDEADBEEF next cycle.
// - DBG-only read of 0x10 -> dbg_gnt=1 same cycle, dbg_rvalid=1 and
//   dbg_rdata=0xDEADBEEF one cycle later.
// - Contention, STARVE_MAX=4, both requesting continuously -> CPU wins 4 cycles
//   (dbg_wait 1..4), DBG wins 5th with cpu_stall=1, then CPU wins again.
// - Lock: DBG writes 0x00,0x04,0x08 with dbg_lock=1 while cpu_rd held -> cpu_stall=1
//   for all 3 plus the dbg_lock=0 cycle; CPU granted the following cycle.
// - reset=0 asserted mid-LOCK with dbg_we=1 -> no write occurs (mem_wr=0),
//   dbg_rvalid=0, state ARB after release; memory contents unchanged.
// - Idle: no requests -> mem_rd=mem_wr=0, dbg_gnt=0, cpu_stall=0, dbg_wait=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline MEM stage (CPU)
//   and an external debug/loader master (DBG). One access is granted per
//   cycle. The CPU normally has priority. DBG wins once it has waited
//   STARVE_MAX contended cycles. DBG may also lock the port for multi-beat
//   loads.
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   cpu_rd/wr/addr/wdata/funct3  MEM-stage request
//   cpu_rdata, cpu_stall       load data (raw mem_rdata); pipeline freeze
//   dbg_req/we/lock/addr/wdata  DBG request (word access)
//   dbg_gnt                    DBG access performed this cycle
//   dbg_rvalid, dbg_rdata      registered DBG read return
//   mem_rd/wr/addr/wdata/funct3, mem_rdata  datamemory port
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_lock,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   dbg_wait;
  logic            cpu_act, cpu_gnt;

  assign cpu_act   = cpu_rd | cpu_wr;
  assign cpu_rdata = mem_rdata;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ARB;
    else        state <= state_nxt;
  end

  // next state: the cycle that drops dbg_lock is still DBG-owned
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (dbg_gnt && dbg_lock) state_nxt = LOCK;
      LOCK: if (!dbg_lock)           state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // grant and port mux; everything is held quiet while in reset
  always_comb begin
    dbg_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (reset) begin
      if (state == LOCK) begin
        dbg_gnt = dbg_req;
      end else begin
        dbg_gnt = dbg_req & (~cpu_act | (dbg_wait == WAIT_MAX));
        cpu_gnt = cpu_act & ~dbg_gnt;
      end
    end
    cpu_stall  = reset & cpu_act & ~cpu_gnt;
    mem_rd     = dbg_gnt ? ~dbg_we : (cpu_gnt & cpu_rd);
    mem_wr     = dbg_gnt ?  dbg_we : (cpu_gnt & cpu_wr);
    // the mux rests on the CPU side when DBG is not granted
    mem_addr   = dbg_gnt ? dbg_addr  : cpu_addr;
    mem_wdata  = dbg_gnt ? dbg_wdata : cpu_wdata;
    mem_funct3 = dbg_gnt ? 3'b010    : cpu_funct3;
  end

  // starvation counter and registered DBG read return
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_wait   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (dbg_gnt || !dbg_req)    dbg_wait <= '0;
      else if (dbg_wait != WAIT_MAX) dbg_wait <= dbg_wait + WW'(1);
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_funct3;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  // word-organised data memory: write at posedge, combinational read
  logic [DW-1:0] bmem [0:127];
  always @(posedge clk) if (mem_wr) bmem[mem_addr[8:2]] <= mem_wdata;
  assign mem_rdata = bmem[mem_addr[8:2]];

  // reference model: ownership flag, wait count, read return, memory image
  bit            m_lock;
  int            m_wait;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] mmem [0:127];
  bit            last_stall, last_dgnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // inputs are already driven; check this cycle, advance model, move to next negedge
  task automatic step();
    bit act, gd, gc, erd, ewr, est;
    #1;
    act = cpu_rd | cpu_wr;
    gd = 0; gc = 0;
    if (reset) begin
      if (m_lock)                gd = dbg_req;
      else if (dbg_req && act)   gd = (m_wait == SM);
      else                       gd = dbg_req;
      gc = !m_lock && act && !gd;
    end
    est = reset && act && !gc;
    erd = gd ? !dbg_we : (gc && cpu_rd);
    ewr = gd ?  dbg_we : (gc && cpu_wr);
    chk("dbg_gnt",   dbg_gnt,   gd);
    chk("cpu_stall", cpu_stall, est);
    chk("mem_rd",    mem_rd,    erd);
    chk("mem_wr",    mem_wr,    ewr);
    if (erd || ewr) begin
      chk("mem_addr",   mem_addr,   gd ? dbg_addr : cpu_addr);
      chk("mem_funct3", mem_funct3, gd ? 3'b010   : cpu_funct3);
    end
    if (ewr) chk("mem_wdata", mem_wdata, gd ? dbg_wdata : cpu_wdata);
    if (gc && cpu_rd) chk("cpu_rdata", cpu_rdata, mmem[cpu_addr[8:2]]);
    chk("dbg_rvalid", dbg_rvalid, m_rv);
    chk("dbg_rdata",  dbg_rdata,  m_rd);
    if (!reset) begin
      m_lock = 0; m_wait = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_rv = gd && !dbg_we;
      if (m_rv) m_rd = mmem[dbg_addr[8:2]];
      m_wait = (gd || !dbg_req) ? 0 : ((m_wait < SM) ? m_wait + 1 : SM);
      m_lock = m_lock ? dbg_lock : (gd && dbg_lock);
      if (ewr) mmem[gd ? dbg_addr[8:2] : cpu_addr[8:2]] = gd ? dbg_wdata : cpu_wdata;
    end
    last_stall = est;
    last_dgnt  = gd;
    @(negedge clk);
  endtask

  task automatic drv(input bit r, input bit crd, input bit cwr, input int ca,
                     input logic [DW-1:0] cwd, input bit dreq, input bit dwe,
                     input bit dl, input int da, input logic [DW-1:0] dwd);
    reset = r; cpu_rd = crd; cpu_wr = cwr; cpu_addr = AW'(ca); cpu_wdata = cwd;
    cpu_funct3 = 3'b010;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dl; dbg_addr = AW'(da); dbg_wdata = dwd;
    step();
  endtask

  initial begin
    int r;
    for (int i = 0; i < 128; i++) begin
      bmem[i] = 32'h0100_0000 + i;
      mmem[i] = 32'h0100_0000 + i;
    end
    m_lock = 0; m_wait = 0; m_rv = 0; m_rd = '0;
    last_stall = 0; last_dgnt = 0;
    reset = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // reset cycle with requests present: everything must stay quiet
    drv(0, 1, 0, 'h10, 0, 1, 1, 1, 'h10, 32'h5555_5555);
    // CPU only: store then load
    drv(1, 0, 1, 'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    // DBG only read
    drv(1, 0, 0, 0, 0, 1, 0, 0, 'h10, 0);
    chk("dbg_rdata_lit", dbg_rdata, 32'hDEAD_BEEF);
    chk("dbg_rvalid_lit", dbg_rvalid, 1'b1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // contention: CPU wins four cycles, DBG the fifth, CPU again after
    for (int i = 0; i < 6; i++) drv(1, 1, 0, 'h10, 0, 1, 0, 0, 'h20, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // locked three-beat load, CPU read held from beat two
    drv(1, 0, 0, 0,    0, 1, 1, 1, 'h00, 32'hA000_0000);
    drv(1, 1, 0, 'h40, 0, 1, 1, 1, 'h04, 32'hA000_0004);
    drv(1, 1, 0, 'h40, 0, 1, 1, 1, 'h08, 32'hA000_0008);
    drv(1, 1, 0, 'h40, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 'h40, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 'h00, 0, 0, 0, 0, 0, 0);
    chk("lock_data", bmem[1], 32'hA000_0004);
    // reset in the middle of a lock drops the pending write
    drv(1, 0, 0, 0, 0, 1, 1, 1, 'h0C, 32'hB000_000C);
    drv(0, 0, 0, 0, 0, 1, 1, 1, 'h10, 32'h1234_5678);
    drv(1, 1, 0, 'h10, 0, 1, 0, 0, 'h14, 0);
    chk("mem_keep", bmem[4], 32'hDEAD_BEEF);
    // idle
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic honouring hold-until-granted on both sides
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      if (!last_stall) begin
        r = $urandom_range(0, 3);
        cpu_rd = (r == 1); cpu_wr = (r == 2);
        cpu_addr = AW'({$urandom_range(0, 127), 2'b00});
        cpu_wdata = $urandom; cpu_funct3 = 3'($urandom_range(0, 7));
      end
      if (!dbg_req || last_dgnt) begin
        dbg_req = ($urandom_range(0, 2) == 0);
        dbg_we = 1'($urandom);
        dbg_addr = AW'({$urandom_range(0, 127), 2'b00});
        dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) dbg_lock = ~dbg_lock;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
